// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : shared constants and types for the RISC-V pipeline stages   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int unsigned ROM_ADDR_WIDTH = 10;
  localparam int unsigned ROM_DATA_WIDTH = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_stage_if : instruction ROM bus between fetch stage and ROM         |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface if_stage_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ROM_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_reg : pipeline register with load, hold and bubble controls     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH   = ROM_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]  BUBBLE_INSTR = DATA_WIDTH'(NOP_INSTR)
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  load,
  input  wire logic                  bubble,
  input  wire logic [31:0]           load_pc,
  input  wire logic [DATA_WIDTH-1:0] load_instr,
  output logic      [31:0]           pc,
  output logic      [DATA_WIDTH-1:0] instr,
  output logic                       valid
);

  logic [31:0]           r_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_valid;

  // Bubble wins over load; a bubble keeps the PC but always clears valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= 32'd0;
      r_instr <= BUBBLE_INSTR;
      r_valid <= 1'b0;
    end else if (bubble) begin
      r_instr <= BUBBLE_INSTR;
      r_valid <= 1'b0;
    end else if (load) begin
      r_pc    <= load_pc;
      r_instr <= load_instr;
      r_valid <= 1'b1;
    end
  end

  assign pc    = r_pc;
  assign instr = r_instr;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_stage : instruction fetch with stall, redirect and sticky halt     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ROM_DATA_WIDTH,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  stall,
  input  wire logic                  redirect_valid,
  input  wire logic [31:0]           redirect_target,
  input  wire logic                  halt,
  if_stage_if.master                 rom_bus,
  output logic      [31:0]           pc_out,
  output logic      [31:0]           id_pc,
  output logic      [DATA_WIDTH-1:0] id_instr,
  output logic                       id_valid,
  output logic                       halted
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic         r_halted;
  logic         w_load;
  logic         w_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FETCH_RUN;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_pc     <= w_pc_next;
      r_halted <= (w_next_state == FETCH_HALT);
    end
  end

  // Priority in RUN: halt, then redirect (even under stall), then stall.
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_bubble     = 1'b0;
    case (r_state)
      FETCH_RUN: begin
        if (halt) begin
          w_next_state = FETCH_HALT;
          w_bubble     = 1'b1;
        end else if (redirect_valid) begin
          w_pc_next = align_word(redirect_target);
          w_bubble  = 1'b1;
        end else if (!stall) begin
          w_pc_next = r_pc + 32'd4;
          w_load    = 1'b1;
        end
      end
      FETCH_HALT: begin
        w_bubble = 1'b1;
      end
      default: begin
        w_next_state = FETCH_RUN;
      end
    endcase
  end

  if_id_reg #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BUBBLE_INSTR (DATA_WIDTH'(NOP_INSTR))
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .bubble     (w_bubble),
    .load_pc    (r_pc),
    .load_instr (rom_bus.rom_data),
    .pc         (id_pc),
    .instr      (id_instr),
    .valid      (id_valid)
  );

  // Upper PC bits are dropped, so the ROM address wraps silently.
  assign rom_bus.rom_addr = r_pc[ADDR_WIDTH+1:2];
  assign pc_out           = r_pc;
  assign halted           = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_stage : directed and randomized checks of the fetch stage       |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_if_stage;
  import cpu_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_target;
  logic          halt;
  logic [31:0]   pc_out;
  logic [31:0]   id_pc;
  logic [DW-1:0] id_instr;
  logic          id_valid;
  logic          halted;

  logic [DW-1:0] rom [0:(1<<AW)-1];

  if_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rom_bus ();
  assign rom_bus.rom_data = rom[rom_bus.rom_addr];

  if_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .rom_bus         (rom_bus),
    .pc_out          (pc_out),
    .id_pc           (id_pc),
    .id_instr        (id_instr),
    .id_valid        (id_valid),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0]   m_pc;
  logic [31:0]   m_id_pc;
  logic [DW-1:0] m_id_instr;
  logic          m_id_valid;
  logic          m_halted;

  task automatic model_reset();
    m_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = NOP_INSTR;
    m_id_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_edge();
    if (m_halted) begin
      m_id_instr = NOP_INSTR; m_id_valid = 1'b0;
    end else if (halt) begin
      m_halted = 1'b1; m_id_instr = NOP_INSTR; m_id_valid = 1'b0;
    end else if (redirect_valid) begin
      m_pc = {redirect_target[31:2], 2'b00};
      m_id_instr = NOP_INSTR; m_id_valid = 1'b0;
    end else if (!stall) begin
      m_id_instr = rom[m_pc[AW+1:2]];
      m_id_pc    = m_pc;
      m_id_valid = 1'b1;
      m_pc       = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 0; redirect_valid = 0; redirect_target = 0; halt = 0;
    model_reset();
    tick(); tick();
    n_vec++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h exp %h", pc_out, 32'h0); end
    n_vec++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL reset_id_pc: got %h exp %h", id_pc, 32'h0); end
    n_vec++; if (id_instr !== NOP_INSTR) begin n_err++; $display("FAIL reset_id_instr: got %h exp %h", id_instr, NOP_INSTR); end
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid: got %b exp 0", id_valid); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b exp 0", halted); end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    logic [31:0] exp_instr [0:1];
    exp_instr[0] = 32'h11; exp_instr[1] = 32'h22;
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (rom_bus.rom_addr !== AW'(i)) begin n_err++; $display("FAIL run_rom_addr%0d: got %h exp %h", i, rom_bus.rom_addr, i); end
      n_vec++; if (id_valid !== (i != 0)) begin n_err++; $display("FAIL run_valid_pre%0d: got %b exp %b", i, id_valid, i != 0); end
      tick();
      n_vec++; if (id_instr !== exp_instr[i]) begin n_err++; $display("FAIL run_instr%0d: got %h exp %h", i, id_instr, exp_instr[i]); end
      n_vec++; if (id_pc !== 32'(4*i)) begin n_err++; $display("FAIL run_id_pc%0d: got %h exp %h", i, id_pc, 4*i); end
      n_vec++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL run_valid%0d: got %b exp 1", i, id_valid); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (pc_out !== 32'h8) begin n_err++; $display("FAIL stall_pc%0d: got %h exp 8", i, pc_out); end
      n_vec++; if (rom_bus.rom_addr !== AW'(2)) begin n_err++; $display("FAIL stall_rom_addr%0d: got %h exp 2", i, rom_bus.rom_addr); end
      n_vec++; if (id_pc !== 32'h4 || id_instr !== 32'h22) begin n_err++; $display("FAIL stall_id%0d: got %h/%h exp 4/22", i, id_pc, id_instr); end
    end
    stall = 1'b0;
    tick();
    n_vec++; if (id_pc !== 32'h8 || id_instr !== 32'h33) begin n_err++; $display("FAIL stall_release: got %h/%h exp 8/33", id_pc, id_instr); end
    n_vec++; if (rom_bus.rom_addr !== AW'(3)) begin n_err++; $display("FAIL stall_next_addr: got %h exp 3", rom_bus.rom_addr); end
    tick();
    n_vec++; if (id_pc !== 32'hC || id_instr !== 32'h44) begin n_err++; $display("FAIL run_fourth: got %h/%h exp c/44", id_pc, id_instr); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0042;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    n_vec++; if (pc_out !== 32'h40) begin n_err++; $display("FAIL redir_pc: got %h exp 40", pc_out); end
    n_vec++; if (rom_bus.rom_addr !== AW'(16)) begin n_err++; $display("FAIL redir_rom_addr: got %h exp 10", rom_bus.rom_addr); end
    n_vec++; if (id_instr !== NOP_INSTR || id_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble: got %h/%b exp 13/0", id_instr, id_valid); end
    tick();
    n_vec++; if (id_pc !== 32'h40 || id_valid !== 1'b1 || id_instr !== rom[16]) begin
      n_err++; $display("FAIL redir_first: got %h/%b/%h exp 40/1/%h", id_pc, id_valid, id_instr, rom[16]); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0FFC;
    tick();
    redirect_valid = 1'b0;
    n_vec++; if (rom_bus.rom_addr !== AW'(10'h3FF)) begin n_err++; $display("FAIL wrap_addr_hi: got %h exp 3ff", rom_bus.rom_addr); end
    tick();
    n_vec++; if (pc_out !== 32'h1000 || rom_bus.rom_addr !== AW'(0)) begin n_err++; $display("FAIL wrap_addr_lo: got %h/%h exp 1000/0", pc_out, rom_bus.rom_addr); end
    n_vec++; if (id_pc !== 32'hFFC || id_instr !== rom[1023]) begin n_err++; $display("FAIL wrap_id: got %h/%h exp ffc/%h", id_pc, id_instr, rom[1023]); end
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_vec++; if (pc_out !== 32'h0 || id_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc32: got %h/%h exp 0/fffffffc", pc_out, id_pc); end
  endtask

  task automatic test_halt();
    logic [31:0] held_pc;
    held_pc = pc_out;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_vec++; if (halted !== 1'b1 || id_valid !== 1'b0 || pc_out !== held_pc) begin
      n_err++; $display("FAIL halt_enter: got %b/%b/%h exp 1/0/%h", halted, id_valid, pc_out, held_pc); end
    for (int i = 0; i < 4; i++) begin
      redirect_valid = 1'b1; redirect_target = $urandom; stall = 1'($urandom);
      tick();
      n_vec++; if (halted !== 1'b1 || id_valid !== 1'b0 || id_instr !== NOP_INSTR || pc_out !== held_pc) begin
        n_err++; $display("FAIL halt_hold%0d: got %b/%b/%h/%h exp 1/0/13/%h", i, halted, id_valid, id_instr, pc_out, held_pc); end
    end
    redirect_valid = 1'b0; stall = 1'b0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    n_vec++; if (pc_out !== 32'h0 || halted !== 1'b0 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL halt_async_rst: got %h/%b/%b exp 0/0/0", pc_out, halted, id_valid); end
    tick();
  endtask

  task automatic test_redirect_after_reset();
    rst = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    n_vec++; if (pc_out !== 32'h100 || id_valid !== 1'b0) begin n_err++; $display("FAIL rst_redir_pc: got %h/%b exp 100/0", pc_out, id_valid); end
    tick();
    n_vec++; if (id_pc !== 32'h100 || id_valid !== 1'b1 || id_instr !== rom[64]) begin
      n_err++; $display("FAIL rst_redir_first: got %h/%b/%h exp 100/1/%h", id_pc, id_valid, id_instr, rom[64]); end
  endtask

  task automatic test_random();
    int halt_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_halted && halt_cycles > 6) begin
        rst = 1'b1; halt = 0; redirect_valid = 0; stall = 0;
        #2;
        model_reset();
        n_vec++; if (pc_out !== 32'h0 || halted !== 1'b0) begin n_err++; $display("FAIL rnd_rst%0d: got %h/%b exp 0/0", i, pc_out, halted); end
        tick();
        rst = 1'b0; halt_cycles = 0;
      end
      stall           = ($urandom % 4) == 0;
      redirect_valid  = ($urandom % 7) == 0;
      redirect_target = ($urandom % 2) ? $urandom : 32'($urandom % 4096);
      halt            = ($urandom % 60) == 0;
      tick();
      if (m_halted) halt_cycles++;
      n_vec++; if (pc_out !== m_pc) begin n_err++; $display("FAIL rnd_pc%0d: got %h exp %h", i, pc_out, m_pc); end
      n_vec++; if (rom_bus.rom_addr !== m_pc[AW+1:2]) begin n_err++; $display("FAIL rnd_addr%0d: got %h exp %h", i, rom_bus.rom_addr, m_pc[AW+1:2]); end
      n_vec++; if (id_pc !== m_id_pc) begin n_err++; $display("FAIL rnd_id_pc%0d: got %h exp %h", i, id_pc, m_id_pc); end
      n_vec++; if (id_instr !== m_id_instr) begin n_err++; $display("FAIL rnd_instr%0d: got %h exp %h", i, id_instr, m_id_instr); end
      n_vec++; if (id_valid !== m_id_valid) begin n_err++; $display("FAIL rnd_valid%0d: got %b exp %b", i, id_valid, m_id_valid); end
      n_vec++; if (halted !== m_halted) begin n_err++; $display("FAIL rnd_halted%0d: got %b exp %b", i, halted, m_halted); end
    end
    halt = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_halt();
    test_redirect_after_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
